k2red_mul_stage: RTL
====================

K2RED_MUL_STAGE -- requirements
Module: k2red_mul_stage

Interface
REQ-001 SHALL have parameter W, default 32, operand/modulus width; product width is 2*W.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  input operand pair is valid this cycle.
REQ-005 SHALL have port in_ready  output  1  stage accepts the input this cycle.
REQ-006 SHALL have ports X and Y, each input, W bits: multiplicands, both < Q.
REQ-007 SHALL have port Q_in  input  W  modulus q = k*2^m + 1 (sideband).
REQ-008 SHALL have ports l1_in, l2_in, l3_in and m_in, each input, 6 bits: K2RED shape parameters (sideband).
REQ-009 SHALL have port out_valid  output  1  A/sideband valid for the downstream k2red_ln_shift.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the output.
REQ-011 SHALL have port A  output  2*W  full product X*Y.
REQ-012 SHALL have ports Q, l1, l2, l3 and m, each output, widths as the matching inputs: sideband aligned with A.

Function
REQ-013 SHALL be a 3-stage pipeline: S1 registers operands split into W/2 halves; S2 registers four (W/2)x(W/2) partial products; S3 registers the shifted sum as A.
REQ-014 SHALL have a latency of exactly 3 cycles from an accepted input (in_valid & in_ready at edge N) to out_valid at edge N+3 when out_ready is held high.
REQ-015 SHALL sustain a throughput of one product per cycle while out_ready=1.
REQ-016 SHALL define advance = !out_valid | out_ready and drive in_ready = advance combinationally.
REQ-017 SHALL move all stage registers and per-stage valid bits together only when advance=1; when advance=0 every stage holds.
REQ-018 SHALL not collapse internal bubbles; an invalid stage still occupies its slot.
REQ-019 SHALL hold A, out_valid and the sideband stable while out_valid=1 and out_ready=0.
REQ-020 SHALL carry the sideband (Q, l1, l2, l3, m) through three registers in lockstep with its own operands, so different moduli may be interleaved cycle by cycle.
REQ-021 SHALL compute A = P_hh<<W + (P_hl+P_lh)<<(W/2) + P_ll, with the middle sum carried at W+1 bits; the result SHALL be exact modulo 2^(2W), with no truncation for any W-bit operands.
REQ-022 SHALL clock no data register when its valid bit is 0; such registers hold their previous value.
REQ-023 SHALL drive A to the product when out_valid=1 and hold the last product otherwise.
REQ-024 SHALL accept in_valid with in_ready=0 without any side effect; the upstream holds the data.

Reset
REQ-025 SHALL, while rst=0, asynchronously clear all stage valid bits; out_valid=0, A=0, and Q, l1, l2, l3, m=0.
REQ-026 SHALL, on reset asserted mid-operation, discard all in-flight products; no stale output appears after release.
REQ-027 SHALL make in_ready=1 in the first cycle after rst deasserts, because out_valid=0.

Structure
REQ-028 SHALL place the W default and the sideband width (6) as constants in the shared k2red package, used by this stage and k2red_ln_shift.
REQ-029 SHALL instantiate a single sub-module k2red_pp_mul, a registered (W/2)x(W/2) multiplier, four times in S2; all other logic is inline.

Verification
REQ-030 SHALL verify single transaction: X=3, Y=5, Q_in=2148794369, l1_in=2, l2_in=1, l3_in=3, m_in=17, out_ready=1 -> out_valid rises exactly 3 cycles later with A=15 and sideband equal to the inputs.
REQ-031 SHALL verify max operands: X=Y=32'hFFFFFFFF -> A=64'hFFFFFFFE00000001.
REQ-032 SHALL verify cross-half carry: X=Y=65536 -> A=4294967296; X=32'h0000FFFF, Y=32'hFFFF0000 -> A=64'h0000FFFE00010000.
REQ-033 SHALL verify back-to-back streaming: 8 consecutive accepted pairs (i, i+1) for i=1..8 -> 8 consecutive out_valid cycles with A=i*(i+1), in order.
REQ-034 SHALL verify backpressure: out_ready=0 for 4 cycles during streaming -> in_ready=0, A held constant, no product lost or duplicated after out_ready=1.
REQ-035 SHALL verify reset mid-stream: rst=0 with 2 products in flight -> out_valid=0 immediately; after release, only newly issued products emerge.
REQ-036 SHALL verify end-to-end: chain the stage with k2red_ln_shift using Q=2148794369, l1=2, l2=1, l3=3, m=17 -> C2 equals k^2*X*Y mod q per the reference model.

Source files
------------

// File: rtl/k2red_pkg.sv
// k2red_pkg: shared constants and sideband shape type for the K2RED pipeline stages.
package k2red_pkg;
  localparam int K2RED_W = 32;
  localparam int SB_W = 6;
  typedef struct packed {
    logic [SB_W-1:0] l1;
    logic [SB_W-1:0] l2;
    logic [SB_W-1:0] l3;
    logic [SB_W-1:0] m;
  } shape_t;
endpackage

// File: rtl/k2red_pp_mul.sv
// k2red_pp_mul: registered HW x HW unsigned multiplier with load enable.
module k2red_pp_mul #(
  parameter int HW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [HW-1:0]   a,
  input  logic [HW-1:0]   b,
  output logic [2*HW-1:0] p
);
  logic [2*HW-1:0] p_d, p_q;
  always_comb p_d = en ? {{HW{1'b0}}, a} * {{HW{1'b0}}, b} : p_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) p_q <= '0;
    else p_q <= p_d;
  assign p = p_q;
endmodule

// File: rtl/k2red_mul_stage.sv
// k2red_mul_stage: 3-stage W x W multiplier (split halves, partial products, sum)
// with elastic stall and a modulus/shape sideband carried in lockstep.
module k2red_mul_stage
  import k2red_pkg::*;
#(
  parameter int W = K2RED_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     X,
  input  logic [W-1:0]     Y,
  input  logic [W-1:0]     Q_in,
  input  logic [SB_W-1:0]  l1_in,
  input  logic [SB_W-1:0]  l2_in,
  input  logic [SB_W-1:0]  l3_in,
  input  logic [SB_W-1:0]  m_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   A,
  output logic [W-1:0]     Q,
  output logic [SB_W-1:0]  l1,
  output logic [SB_W-1:0]  l2,
  output logic [SB_W-1:0]  l3,
  output logic [SB_W-1:0]  m
);
  localparam int H = W / 2;
  logic advance, ld1, ld2, ld3;
  logic v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
  logic [W-1:0] x1_d, x1_q, y1_d, y1_q;
  logic [W-1:0] q1_d, q1_q, q2_d, q2_q, q3_d, q3_q;
  shape_t sh_in, sh1_d, sh1_q, sh2_d, sh2_q, sh3_d, sh3_q;
  logic [W-1:0] p_hh, p_hl, p_lh, p_ll;
  logic [W:0] mid;
  logic [2*W-1:0] sum, a_d, a_q;
  assign advance = !v3_q | out_ready;
  assign in_ready = advance;
  assign ld1 = advance & in_valid;
  assign ld2 = advance & v1_q;
  assign ld3 = advance & v2_q;
  assign sh_in = '{l1: l1_in, l2: l2_in, l3: l3_in, m: m_in};
  k2red_pp_mul #(.HW(H)) u_hh (.clk(clk), .rst(rst), .en(ld2), .a(x1_q[W-1:H]), .b(y1_q[W-1:H]), .p(p_hh));
  k2red_pp_mul #(.HW(H)) u_hl (.clk(clk), .rst(rst), .en(ld2), .a(x1_q[W-1:H]), .b(y1_q[H-1:0]), .p(p_hl));
  k2red_pp_mul #(.HW(H)) u_lh (.clk(clk), .rst(rst), .en(ld2), .a(x1_q[H-1:0]), .b(y1_q[W-1:H]), .p(p_lh));
  k2red_pp_mul #(.HW(H)) u_ll (.clk(clk), .rst(rst), .en(ld2), .a(x1_q[H-1:0]), .b(y1_q[H-1:0]), .p(p_ll));
  // Middle term needs W+1 bits so the two cross products never lose their carry.
  assign mid = {1'b0, p_hl} + {1'b0, p_lh};
  assign sum = {p_hh, p_ll} + ({{(W-1){1'b0}}, mid} << H);
  always_comb begin
    v1_d  = advance ? in_valid : v1_q;
    v2_d  = advance ? v1_q : v2_q;
    v3_d  = advance ? v2_q : v3_q;
    x1_d  = ld1 ? X : x1_q;
    y1_d  = ld1 ? Y : y1_q;
    q1_d  = ld1 ? Q_in : q1_q;
    sh1_d = ld1 ? sh_in : sh1_q;
    q2_d  = ld2 ? q1_q : q2_q;
    sh2_d = ld2 ? sh1_q : sh2_q;
    q3_d  = ld3 ? q2_q : q3_q;
    sh3_d = ld3 ? sh2_q : sh3_q;
    a_d   = ld3 ? sum : a_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      x1_q <= '0;
      y1_q <= '0;
      q1_q <= '0;
      q2_q <= '0;
      q3_q <= '0;
      sh1_q <= '0;
      sh2_q <= '0;
      sh3_q <= '0;
      a_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      x1_q <= x1_d;
      y1_q <= y1_d;
      q1_q <= q1_d;
      q2_q <= q2_d;
      q3_q <= q3_d;
      sh1_q <= sh1_d;
      sh2_q <= sh2_d;
      sh3_q <= sh3_d;
      a_q <= a_d;
    end
  assign out_valid = v3_q;
  assign A = a_q;
  assign Q = q3_q;
  assign l1 = sh3_q.l1;
  assign l2 = sh3_q.l2;
  assign l3 = sh3_q.l3;
  assign m = sh3_q.m;
endmodule
